// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state type, width helper and reset constants for the note sequencer
package note_seq_pkg;
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  localparam logic RST_OUT = 1'b0;
  localparam logic RST_DONE = 1'b0;
  function automatic int aw_of(input int notes);
    return (notes < 2) ? 1 : $clog2(notes);
  endfunction
endpackage

// File: rtl/note_sequencer_tone_gen.sv
// tone_gen: half-period counter and toggle flop producing the square wave; div=0 is silence
module tone_gen
  import note_seq_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_out
);
  logic [DIV_W-1:0] r_cnt;
  logic             r_out;
  logic             w_wrap;
  logic             w_hold;
  assign w_wrap = (r_cnt == i_div - DIV_W'(1));
  assign w_hold = !i_rstn || i_clr || !i_en || (i_div == '0);
  assign o_out  = r_out;
  // count 0..div-1 and toggle on wrap; cleared on note load, when idle, or when silent
  always_ff @(posedge i_clk) begin
    if (w_hold) begin
      r_cnt <= '0;
      r_out <= RST_OUT;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_out <= ~r_out;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: writable note table played back as a sequenced square wave with rests and looping
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int NOTES = 8,
  parameter int DIV_W = 16,
  parameter int DUR_W = 24,
  parameter int AW    = aw_of(NOTES)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic [DUR_W-1:0] i_wr_dur,
  input  logic [AW:0]      i_len,
  input  logic             i_loop,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_busy,
  output logic [AW-1:0]    o_note_idx,
  output logic             o_done,
  output logic             o_out
);
  logic [DIV_W-1:0] r_div [NOTES];
  logic [DUR_W-1:0] r_dur [NOTES];
  state_t           r_state;
  logic [AW:0]      r_len;
  logic             r_loop;
  logic [AW-1:0]    r_idx;
  logic [DIV_W-1:0] r_cur_div;
  logic [DUR_W-1:0] r_cur_dur;
  logic [DUR_W-1:0] r_dcnt;
  logic             r_done;
  logic             w_go;
  logic             w_last;
  logic             w_has_next;
  logic [AW-1:0]    w_next_idx;
  logic [AW-1:0]    w_load_addr;
  logic [AW:0]      w_len_eff;
  logic             w_tone_clr;
  assign w_go        = (r_state == IDLE) && i_start && !i_stop && (i_len != '0);
  assign w_len_eff   = (i_len > (AW+1)'(NOTES)) ? (AW+1)'(NOTES) : i_len;
  assign w_last      = (r_cur_dur <= DUR_W'(1)) ? (r_dcnt == '0) : (r_dcnt == r_cur_dur - DUR_W'(1));
  assign w_has_next  = ({1'b0, r_idx} + (AW+1)'(1)) < r_len;
  assign w_next_idx  = w_has_next ? r_idx + AW'(1) : '0;
  assign w_load_addr = w_go ? '0 : w_next_idx;
  assign w_tone_clr  = i_stop || w_last;
  assign o_busy      = (r_state == PLAY);
  assign o_note_idx  = r_idx;
  assign o_done      = r_done;
  // note table: writes land at the edge, so a same-cycle load sees the old entry
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < NOTES; i++) begin
        r_div[i] <= '0;
        r_dur[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_div[i_wr_addr] <= i_wr_div;
      r_dur[i_wr_addr] <= i_wr_dur;
    end
  end
  // sequencing FSM: start latches len/loop and loads entry 0; each note boundary advances, wraps or ends
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_loop    <= 1'b0;
      r_idx     <= '0;
      r_cur_div <= '0;
      r_cur_dur <= '0;
      r_dcnt    <= '0;
      r_done    <= RST_DONE;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_go) begin
          r_state   <= PLAY;
          r_len     <= w_len_eff;
          r_loop    <= i_loop;
          r_idx     <= '0;
          r_cur_div <= r_div[w_load_addr];
          r_cur_dur <= r_dur[w_load_addr];
          r_dcnt    <= '0;
        end
      end else if (i_stop) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_dcnt  <= '0;
      end else if (w_last) begin
        if (w_has_next || r_loop) begin
          r_idx     <= w_next_idx;
          r_cur_div <= r_div[w_load_addr];
          r_cur_dur <= r_dur[w_load_addr];
          r_dcnt    <= '0;
        end else begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_idx   <= '0;
          r_dcnt  <= '0;
        end
      end else begin
        r_dcnt <= r_dcnt + DUR_W'(1);
      end
    end
  end
  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_tone_clr),
    .i_en   (o_busy),
    .i_div  (r_cur_div),
    .o_out  (o_out)
  );
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench comparing per-cycle busy/note_idx/out/done against a note-level model
module tb_note_sequencer;
  localparam int NOTES = 4;
  localparam int DIV_W = 8;
  localparam int DUR_W = 8;
  localparam int AW = 2;
  logic clk = 0, rstn = 0, wr_en = 0, loop = 0, start = 0, stop = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DIV_W-1:0] wr_div = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [AW:0] len = '0;
  logic busy, done, out;
  logic [AW-1:0] note_idx;
  typedef struct packed {logic busy; logic [AW-1:0] idx; logic idx_care; logic out; logic done;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  int sh_div[NOTES], sh_dur[NOTES];

  always #5 clk = ~clk;

  note_sequencer #(.NOTES(NOTES), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_div(wr_div),
    .i_wr_dur(wr_dur), .i_len(len), .i_loop(loop), .i_start(start), .i_stop(stop),
    .o_busy(busy), .o_note_idx(note_idx), .o_done(done), .o_out(out)
  );

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (busy !== e.busy || out !== e.out || done !== e.done || (e.idx_care && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL trace cyc=%0d got busy=%0b idx=%0d out=%0b done=%0b want busy=%0b idx=%0d(care=%0b) out=%0b done=%0b",
                 cyc, busy, note_idx, out, done, e.busy, e.idx, e.idx_care, e.out, e.done);
      end
    end
  end

  function automatic exp_t mk(input logic b, input int i, input logic ic, input logic o, input logic d);
    exp_t r;
    r.busy = b; r.idx = i[AW-1:0]; r.idx_care = ic; r.out = o; r.done = d;
    return r;
  endfunction

  function automatic int span(input int ln);
    int s, leff;
    leff = (ln > NOTES) ? NOTES : ln;
    s = 3;
    for (int i = 0; i < leff; i++) s += (sh_dur[i] == 0) ? 1 : sh_dur[i];
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d, input int u);
    wr_en = 1; wr_addr = a[AW-1:0]; wr_div = d[DIV_W-1:0]; wr_dur = u[DUR_W-1:0];
    tick();
    wr_en = 0; sh_div[a] = d; sh_dur[a] = u;
  endtask

  // ab_k: 0 stop, 1 stop+start together, 2 one-cycle reset; abort sampled at the edge ending cycle ab_c-1
  task automatic run(input int ln, input int lp, input int ncyc, input int ab_c, input int ab_k,
                     input int w0, input int wdiv, input int pulse_c);
    exp_t ex[$];
    int leff, c, n, dv, dd;
    bit fin;
    leff = (ln > NOTES) ? NOTES : ln;
    len = ln[AW:0]; loop = lp[0]; start = 1;
    if (w0 != 0) begin
      wr_en = 1; wr_addr = '0; wr_div = wdiv[DIV_W-1:0]; wr_dur = DUR_W'(sh_dur[0]);
    end
    tick();
    start = 0; wr_en = 0;
    c = 0; n = 0; fin = (leff == 0);
    while (c < ncyc) begin
      if (fin) begin
        ex.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        c++;
      end else begin
        dv = (w0 != 0 && n == 0 && c > 0) ? wdiv : sh_div[n];
        dd = (sh_dur[n] == 0) ? 1 : sh_dur[n];
        for (int k = 0; k < dd && c < ncyc; k++) begin
          ex.push_back(mk(1'b1, n, 1'b1, (dv == 0) ? 1'b0 : 1'((k / dv) % 2), 1'b0));
          c++;
        end
        n++;
        if (n == leff) begin
          if (lp != 0) n = 0;
          else begin
            fin = 1;
            if (c < ncyc) begin
              ex.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1));
              c++;
            end
          end
        end
      end
    end
    if (ab_c >= 0)
      for (int i = ab_c; i < ncyc; i++) ex[i] = mk(1'b0, 0, (ab_k == 2 && i == ab_c), 1'b0, 1'b0);
    if (w0 != 0) sh_div[0] = wdiv;
    foreach (ex[i]) sb.push_back(ex[i]);
    for (int c2 = 0; c2 < ncyc; c2++) begin
      if (c2 == ab_c - 1) begin
        if (ab_k == 2) rstn = 0;
        else begin stop = 1; start = (ab_k == 1); end
      end
      if (c2 == pulse_c) begin start = 1; len = 1; end
      tick();
      stop = 0; start = 0; rstn = 1;
    end
    if (ab_k == 2 && ab_c >= 0)
      for (int i = 0; i < NOTES; i++) begin sh_div[i] = 0; sh_dur[i] = 0; end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    int ln, lp, ab, nc, kd;
    for (int i = 0; i < NOTES; i++) begin sh_div[i] = 0; sh_dur[i] = 0; end
    tick();
    tick();
    sb.push_back(mk(1'b0, 0, 1'b1, 1'b0, 1'b0));
    tick();
    rstn = 1;
    tick();
    wr(0, 3, 12);
    wr(1, 2, 8);
    run(2, 0, span(2), -1, 0, 0, 0, -1);
    wr(1, 0, 5);
    wr(2, 2, 6);
    run(3, 0, span(3), -1, 0, 0, 0, -1);
    run(3, 1, 60, 40, 0, 0, 0, 5);
    run(0, 0, 4, -1, 0, 0, 0, -1);
    wr(3, 1, 3);
    run(7, 0, span(7), -1, 0, 0, 0, 2);
    run(2, 1, 50, 45, 1, 1, 1, -1);
    run(3, 1, 30, 15, 2, 0, 0, -1);
    run(1, 0, span(1), -1, 0, 0, 0, -1);
    repeat (8) begin
      for (int i = 0; i < NOTES; i++) wr(i, int'($urandom_range(4, 0)), int'($urandom_range(9, 0)));
      ln = int'($urandom_range(7, 0));
      lp = int'($urandom_range(1, 0));
      kd = int'($urandom_range(1, 0));
      if (lp != 0) begin
        ab = 10 + int'($urandom_range(40, 0));
        nc = ab + 5;
      end else begin
        nc = span(ln);
        ab = ($urandom_range(1, 0) == 1) ? int'($urandom_range(nc - 1, 1)) : -1;
      end
      run(ln, lp, nc, ab, kd, 0, 0, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Programmable melody player for the buzzer output: a small note table (divisor, duration per entry) that software or a control FSM writes, then plays back as a square wave, note after note, optionally looping. It generalises the fixed 4-tone generator into a parametrised, writable, sequenced tone source with a start/stop handshake and rests. It sits between the board control logic and the buzzer pin.

## Interface
- NOTES, 8: table depth (entries), power of two ≥ 2; AW = clog2(NOTES)
- DIV_W, 16: width of half-period divisor
- DUR_W, 24: width of note duration (clock cycles)
- clk  in  1  system clock; single clock domain
- rstn  in  1  reset, synchronous, active-low
- wr_en  in  1  write table entry wr_addr this cycle
- wr_addr  in  AW  table index
- wr_div  in  DIV_W  half-period in cycles; 0 = rest (silence)
- wr_dur  in  DUR_W  note length in cycles; 0 treated as 1
- len  in  AW+1  notes to play (entries 0..len-1), sampled on start
- loop  in  1  repeat sequence forever, sampled on start
- start  in  1  begin playback (level sampled each cycle)
- stop  in  1  abort playback
- busy  out  1  sequence playing
- note_idx  out  AW  entry currently sounding
- done  out  1  one-cycle pulse at normal sequence end
- out  out  1  square-wave buzzer drive

## Operation
- Reset (rstn=0 at an edge): state IDLE; busy=0, done=0, out=0, note_idx=0; table contents cleared to div=0, dur=0.
- FSM states: IDLE, PLAY.
- IDLE: start=1 with 1 ≤ len ≤ NOTES → latch len, loop; load entry 0 into cur_div/cur_dur; clear tone and duration counters; go PLAY. len=0 → start ignored. len>NOTES → clamped to NOTES.
- PLAY, per cycle: duration counter increments; tone counter counts 0..cur_div-1, wraps, and toggles out at wrap. cur_div=0 → out held 0, tone counter held 0.
- Note boundary (duration counter reaches max(cur_dur,1)-1): if note_idx < len-1 → note_idx+1; elif loop → note_idx=0; else → IDLE, done=1 for that cycle, out=0. On advance: load new entry, clear both counters, out=0.
- stop=1 in PLAY → IDLE next edge, out=0, busy=0, no done. stop and start in the same cycle → stop wins.
- start while busy: ignored. len/loop changes while busy: ignored until next start.
- Writes accepted in any state. A write to the entry being loaded in the same cycle: old value loaded (read-before-write); new value used next time that entry is loaded. Entries already latched are never altered mid-note.

## Timing
- start sampled at edge t → at t+1: busy=1, note_idx=0, out=0.
- Tone: out first rises at t+1+div, period exactly 2·div cycles, 50% duty.
- Note i occupies exactly max(dur_i,1) cycles; the next note starts on the following cycle, no gap.
- Non-loop end: done=1, busy=0 in cycle t+1+Σmax(dur_i,1); done low thereafter.
- stop at edge s → busy=0, out=0 from s+1.
- Counters: tone counter DIV_W bits, duration counter DUR_W bits; no overflow possible since each compares against its own-width limit.

## Structure
- Package note_seq_pkg: state enum (IDLE, PLAY), AW derivation helper, reset constants.
- Sub-module tone_gen: DIV_W counter + toggle flop with synchronous clear and div=0 silence; instantiated once, cleared by the sequencer at each note load.
- Table: NOTES × (DIV_W+DUR_W) register array, combinational read.

## Test plan (NOTES=4, DIV_W=8, DUR_W=8)
- Reset mid-playback (rstn=0 one cycle) → next cycle busy=0, out=0, note_idx=0, table reads div=0.
- Table {div=3,dur=12},{div=2,dur=8}, len=2, loop=0, start → out period 6 for 12 cycles, period 4 for 8 cycles, done pulse exactly 20 cycles after busy rises.
- Entry 1 div=0 dur=5 (rest) between two tones → out=0 for exactly 5 cycles, note_idx=1 during them.
- loop=1, len=3 → note_idx sequence 0,1,2,0,1,… with no gap, done never asserted; stop → busy=0, out=0 next cycle, no done.
- start with len=0 → busy stays 0; len=7 → plays 4 notes then done; start pulsed while busy → no restart.
- Write entry 0 during its own load cycle (loop=1) → first pass uses old div, second pass uses new div; stop+start same cycle → IDLE.
